// File: rtl/uart_frame_pkg.sv
// Shared constants for the UART frame scheduler and the receiver-side checker:
// framing bytes, CRC-32/IEEE parameters and the FSM state encoding.
package uart_frame_pkg;

  localparam int          BYTE_W       = 8;
  localparam logic [7:0]  PREAMBLE     = 8'h7E;
  localparam logic [31:0] CRC32_POLY   = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT   = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_XOROUT = 32'hFFFFFFFF;
  localparam int          CSM_BYTE_NUM = 4;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PRE  = 3'd1;
  localparam logic [2:0] ST_OPT  = 3'd2;
  localparam logic [2:0] ST_LEN  = 3'd3;
  localparam logic [2:0] ST_DATA = 3'd4;
  localparam logic [2:0] ST_CRC  = 3'd5;

  // Final checksum value put on the wire; a poisoned frame sends its complement
  // so the receiver is guaranteed to reject it.
  function automatic logic [31:0] crc32_final(input logic [31:0] crc, input logic poison);
    logic [31:0] v_fin;
    v_fin = crc ^ CRC32_XOROUT;
    return poison ? ~v_fin : v_fin;
  endfunction

endpackage

// File: rtl/uart_frame_tx_sched_if.sv
// Bundle between the frame requesters / byte transmitter (master side) and the
// scheduler (slave side).
//
// Handshakes: every valid/ready pair transfers exactly on a rising CLK edge
// where both are high. The source holds valid and its payload stable until that
// transfer; ready may depend combinationally on valid's counterpart state but
// never on the source's payload. req_valid is a level held until done/err.
interface uart_frame_tx_sched_if #(
  parameter int N_REQ = 4
);
  import uart_frame_pkg::*;

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*BYTE_W-1:0] req_opt;
  logic [N_REQ*BYTE_W-1:0] req_len;
  logic [N_REQ-1:0]        dat_valid;
  logic [N_REQ*BYTE_W-1:0] dat_byte;
  logic [N_REQ-1:0]        dat_ready;
  logic [N_REQ-1:0]        done;
  logic [N_REQ-1:0]        err;
  logic [N_REQ-1:0]        grant;
  logic                    tx_valid;
  logic [BYTE_W-1:0]       tx_byte;
  logic                    tx_ready;
  logic                    busy;

  modport master (
    output req_valid, req_opt, req_len, dat_valid, dat_byte, tx_ready,
    input  dat_ready, done, err, grant, tx_valid, tx_byte, busy
  );

  modport slave (
    input  req_valid, req_opt, req_len, dat_valid, dat_byte, tx_ready,
    output dat_ready, done, err, grant, tx_valid, tx_byte, busy
  );

endinterface

// File: rtl/uart_frame_tx_sched_crc32.sv
// One-byte CRC-32/IEEE step (reflected polynomial, LSB first), purely
// combinational so both transmit and receive paths can share it.
module crc32_byte_upd
  import uart_frame_pkg::*;
(
  input  logic [31:0] i_crc,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_crc
);

  // Eight bit-serial shift/xor steps unrolled into one cycle.
  always_comb begin
    o_crc = i_crc ^ {24'h0, i_byte};
    for (int b = 0; b < 8; b++) begin
      o_crc = o_crc[0] ? ((o_crc >> 1) ^ CRC32_POLY) : (o_crc >> 1);
    end
  end

endmodule

// File: rtl/uart_frame_tx_sched.sv
// Round-robin owner of a single UART byte transmitter. Each granted frame goes
// out as PRE, OPT, LEN, LEN data bytes, then a 4-byte CRC-32 (MSB first).
// A requester that stops supplying data is padded with zeros and its frame is
// closed with a complemented CRC so the far end drops it.
module uart_frame_tx_sched #(
  parameter int         N_REQ     = 4,
  parameter int         BYTE_SIZE = 8,
  parameter logic [7:0] PREAMBLE  = uart_frame_pkg::PREAMBLE,
  parameter int         STALL_MAX = 255
) (
  input  logic                CLK,
  input  logic                RST,
  uart_frame_tx_sched_if.slave bus,
  output logic [2:0]          o_dbg_state
);
  import uart_frame_pkg::*;

  localparam int IW = $clog2(N_REQ);
  localparam int SW = $clog2(STALL_MAX + 1);

  logic [2:0]           r_state;
  logic [N_REQ-1:0]     r_grant;
  logic [IW-1:0]        r_rr_ptr;
  logic [BYTE_SIZE-1:0] r_opt;
  logic [BYTE_SIZE-1:0] r_len;
  logic [BYTE_SIZE-1:0] r_cnt;
  logic [BYTE_SIZE-1:0] r_tx_byte;
  logic                 r_tx_valid;
  logic [N_REQ-1:0]     r_done;
  logic [N_REQ-1:0]     r_err;
  logic [31:0]          r_crc;
  logic [SW-1:0]        r_stall_cnt;
  logic                 r_stalled;
  logic [1:0]           r_csm_idx;

  logic                 w_hit;
  logic [IW-1:0]        w_win;
  logic [IW-1:0]        w_scan;
  logic                 w_xfer;
  logic [31:0]          w_crc_next;
  logic [31:0]          w_crc_out;
  logic                 w_dat_valid_g;
  logic [BYTE_SIZE-1:0] w_dat_byte_g;
  logic                 w_ld_rdy;
  logic                 w_ld;

  crc32_byte_upd u_crc (
    .i_crc  (r_crc),
    .i_byte (r_tx_byte),
    .o_crc  (w_crc_next)
  );

  // Round-robin search starting just after the last winner; the lowest offset wins.
  always_comb begin
    w_hit  = 1'b0;
    w_win  = '0;
    w_scan = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      w_scan = IW'((int'(r_rr_ptr) + k) % N_REQ);
      if (bus.req_valid[w_scan]) begin
        w_hit = 1'b1;
        w_win = w_scan;
      end
    end
  end

  assign w_xfer        = r_tx_valid & bus.tx_ready;
  assign w_dat_valid_g = bus.dat_valid[r_rr_ptr];
  assign w_dat_byte_g  = bus.dat_byte[BYTE_SIZE*r_rr_ptr +: BYTE_SIZE];
  // The tx register can take a new data byte when empty or draining this cycle.
  assign w_ld_rdy      = (r_state == ST_DATA) & (r_cnt != r_len) & (~r_tx_valid | bus.tx_ready);
  // Once stalled, zero pads stand in for the missing requester data.
  assign w_ld          = w_ld_rdy & (r_stalled | w_dat_valid_g);
  assign w_crc_out     = crc32_final(w_crc_next, r_stalled);

  // Frame sequencer: arbitration, byte presentation, CRC accumulation, stall abort.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_grant     <= '0;
      r_rr_ptr    <= IW'(N_REQ - 1);
      r_opt       <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_tx_byte   <= '0;
      r_tx_valid  <= 1'b0;
      r_done      <= '0;
      r_err       <= '0;
      r_crc       <= CRC32_INIT;
      r_stall_cnt <= '0;
      r_stalled   <= 1'b0;
      r_csm_idx   <= '0;
    end else begin
      r_done <= '0;
      r_err  <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_hit) begin
            r_grant     <= {{(N_REQ-1){1'b0}}, 1'b1} << w_win;
            r_rr_ptr    <= w_win;
            r_opt       <= bus.req_opt[BYTE_SIZE*w_win +: BYTE_SIZE];
            r_len       <= bus.req_len[BYTE_SIZE*w_win +: BYTE_SIZE];
            r_crc       <= CRC32_INIT;
            r_cnt       <= '0;
            r_stall_cnt <= '0;
            r_stalled   <= 1'b0;
            r_tx_valid  <= 1'b1;
            r_tx_byte   <= PREAMBLE;
            r_state     <= ST_PRE;
          end
        end
        ST_PRE: begin
          if (w_xfer) begin
            r_tx_byte <= r_opt;
            r_state   <= ST_OPT;
          end
        end
        ST_OPT: begin
          if (w_xfer) begin
            r_crc     <= w_crc_next;
            r_tx_byte <= r_len;
            r_state   <= ST_LEN;
          end
        end
        ST_LEN: begin
          if (w_xfer) begin
            if (r_len == '0) begin
              r_crc     <= w_crc_out;
              r_tx_byte <= w_crc_out[31:24];
              r_csm_idx <= '0;
              r_state   <= ST_CRC;
            end else begin
              r_crc      <= w_crc_next;
              r_tx_valid <= 1'b0;
              r_state    <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (w_xfer) r_crc <= w_crc_next;
          if (w_ld) begin
            r_tx_byte   <= r_stalled ? '0 : w_dat_byte_g;
            r_tx_valid  <= 1'b1;
            r_cnt       <= r_cnt + 8'd1;
            r_stall_cnt <= '0;
          end else if (w_xfer) begin
            if (r_cnt == r_len) begin
              r_crc     <= w_crc_out;
              r_tx_byte <= w_crc_out[31:24];
              r_csm_idx <= '0;
              r_state   <= ST_CRC;
            end else begin
              r_tx_valid <= 1'b0;
            end
          end else if (!r_tx_valid && !r_stalled) begin
            if (r_stall_cnt == SW'(STALL_MAX)) r_stalled   <= 1'b1;
            else                               r_stall_cnt <= r_stall_cnt + 1'b1;
          end
        end
        ST_CRC: begin
          if (w_xfer) begin
            if (r_csm_idx == 2'(CSM_BYTE_NUM - 1)) begin
              r_tx_valid <= 1'b0;
              r_grant    <= '0;
              r_done     <= r_stalled ? '0 : r_grant;
              r_err      <= r_stalled ? r_grant : '0;
              r_state    <= ST_IDLE;
            end else begin
              r_tx_byte <= r_crc[23:16];
              r_crc     <= r_crc << 8;
              r_csm_idx <= r_csm_idx + 2'd1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.dat_ready = r_grant & {N_REQ{w_ld_rdy & ~r_stalled}};
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.grant     = r_grant;
  assign bus.tx_valid  = r_tx_valid;
  assign bus.tx_byte   = r_tx_byte;
  assign bus.busy      = (r_state != ST_IDLE);
  assign o_dbg_state   = r_state;

endmodule
